mem_port_arbiter: RTL and testbench

Shares the single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw). It arbitrates between the two requesters and sequences each memory transaction through a req/ack handshake. It returns read data and a one-cycle ready pulse to the winner and drives the stall signals that freeze the pipeline while a stage waits. It also discards fetches that complete after a branch or ecall flush.

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state;
    logic          cancel_pending;
    logic [CW-1:0] starve_cnt;
    logic          d_grant;
    logic [CW-1:0] starve_next;

    // data wins unless a waiting fetch has already been passed over STARVE_LIMIT times
    always_comb begin
        d_grant     = d_req && (!i_req || STARVE_LIMIT == 0 || starve_cnt < LIM);
        starve_next = !i_req ? '0 : (starve_cnt == LIM ? starve_cnt : starve_cnt + 1'b1);
    end

    // ready pulses come straight from mem_ack; a flushed fetch never reports ready
    always_comb begin
        i_ready     = state == BUSY_I && mem_ack && !(cancel_pending || i_flush);
        d_ready     = state == BUSY_D && mem_ack;
        i_rdata     = mem_rdata;
        d_rdata     = mem_rdata;
        stall_fetch = i_req && !i_ready;
        stall_mem   = d_req && !d_ready;
    end

    // grant in IDLE, hold the latched request until mem_ack, then spend one cycle back in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            cancel_pending <= 1'b0;
            starve_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_grant) begin
                        state      <= BUSY_D;
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        starve_cnt <= starve_next;
                    end else if (i_req) begin
                        state      <= BUSY_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= i_addr;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state          <= IDLE;
                        mem_req        <= 1'b0;
                        cancel_pending <= 1'b0;
                    end else if (i_flush) begin
                        cancel_pending <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, starvation, flush and reset behaviour
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))
module tb_mem_port_arbiter;
  logic        clk, reset;
  logic        i_req, i_flush, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        stall_fetch, stall_mem;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          cnt;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign mem_ack   = mem_req && (cnt == lat - 1);
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 0;
    else if (mem_ack) cnt <= 0;
    else if (mem_req) cnt <= cnt + 1;
  end
  always @(negedge clk) begin
    if (reset) begin
      checks += 3;
      assert (!(mem_ack && !mem_req)) else begin
        errors++;
        $error("FAIL mon_ack_without_req");
      end
      assert (stall_fetch === (i_req && !i_ready)) else begin
        errors++;
        $error("FAIL mon_stall_fetch: observed %b", stall_fetch);
      end
      assert (stall_mem === (d_req && !d_ready)) else begin
        errors++;
        $error("FAIL mon_stall_mem: observed %b", stall_mem);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1; i_req = 0; i_addr = 0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; lat = 3;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_req = 1;
    mid;
    `CHK("rst_mem_req", mem_req, 0);
    `CHK("rst_mem_we", mem_we, 0);
    `CHK("rst_mem_addr", mem_addr, 0);
    `CHK("rst_i_ready", i_ready, 0);
    `CHK("rst_stall_fetch", stall_fetch, 1);
    `CHK("rst_stall_mem", stall_mem, 0);
    i_req = 0;
    reset = 1'b1;
    nxt;
    i_req = 1; i_addr = 32'h4;
    mid; `CHK("f_c0_mem_req", mem_req, 0);
    nxt; mid;
    `CHK("f_c1_mem_req", mem_req, 1);
    `CHK("f_c1_mem_addr", mem_addr, 32'h4);
    `CHK("f_c1_mem_we", mem_we, 0);
    `CHK("f_c1_i_ready", i_ready, 0);
    nxt; mid;
    `CHK("f_c2_mem_req", mem_req, 1);
    `CHK("f_c2_i_ready", i_ready, 0);
    nxt; mid;
    `CHK("f_c3_i_ready", i_ready, 1);
    `CHK("f_c3_i_rdata", i_rdata, 32'h5A5A_0004);
    `CHK("f_c3_stall_fetch", stall_fetch, 0);
    nxt; i_req = 0; mid;
    `CHK("f_c4_mem_req", mem_req, 0);
    `CHK("f_c4_i_ready", i_ready, 0);
    nxt;
    i_req = 1; i_addr = 32'h8;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    mid;
    `CHK("s_c0_stall_fetch", stall_fetch, 1);
    `CHK("s_c0_stall_mem", stall_mem, 1);
    nxt; mid;
    `CHK("s_c1_mem_req", mem_req, 1);
    `CHK("s_c1_mem_we", mem_we, 1);
    `CHK("s_c1_mem_addr", mem_addr, 32'h100);
    `CHK("s_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    `CHK("s_c1_stall_fetch", stall_fetch, 1);
    nxt; mid;
    `CHK("s_c2_d_ready", d_ready, 0);
    nxt; mid;
    `CHK("s_c3_d_ready", d_ready, 1);
    `CHK("s_c3_stall_mem", stall_mem, 0);
    `CHK("s_c3_stall_fetch", stall_fetch, 1);
    `CHK("s_c3_i_ready", i_ready, 0);
    nxt; d_req = 0; d_we = 0; mid;
    `CHK("s_c4_mem_req", mem_req, 0);
    `CHK("s_c4_stall_fetch", stall_fetch, 1);
    nxt; mid;
    `CHK("s_c5_mem_req", mem_req, 1);
    `CHK("s_c5_mem_addr", mem_addr, 32'h8);
    `CHK("s_c5_mem_we", mem_we, 0);
    nxt; nxt; mid;
    `CHK("s_c7_i_ready", i_ready, 1);
    `CHK("s_c7_i_rdata", i_rdata, 32'h5A5A_0008);
    nxt; i_req = 0;
    nxt;
    lat = 1;
    i_req = 1; i_addr = 32'hC; d_req = 1; d_we = 0; d_addr = 32'h200;
    nxt; mid;
    `CHK("v_a1_mem_addr", mem_addr, 32'h200);
    `CHK("v_a1_d_ready", d_ready, 1);
    `CHK("v_a1_d_rdata", d_rdata, 32'h5A5A_0200);
    `CHK("v_a1_stall_fetch", stall_fetch, 1);
    nxt; d_addr = 32'h204; mid;
    `CHK("v_a2_mem_req", mem_req, 0);
    nxt; mid;
    `CHK("v_a3_mem_addr", mem_addr, 32'h204);
    `CHK("v_a3_d_ready", d_ready, 1);
    nxt; d_addr = 32'h208; mid;
    `CHK("v_a4_mem_req", mem_req, 0);
    nxt; mid;
    `CHK("v_a5_mem_addr", mem_addr, 32'hC);
    `CHK("v_a5_mem_we", mem_we, 0);
    `CHK("v_a5_i_ready", i_ready, 1);
    `CHK("v_a5_i_rdata", i_rdata, 32'h5A5A_000C);
    `CHK("v_a5_d_ready", d_ready, 0);
    `CHK("v_a5_stall_mem", stall_mem, 1);
    nxt; i_addr = 32'h10; mid;
    `CHK("v_a6_mem_req", mem_req, 0);
    nxt; mid;
    `CHK("v_a7_mem_addr", mem_addr, 32'h208);
    `CHK("v_a7_d_ready", d_ready, 1);
    nxt; i_req = 0; d_req = 0;
    nxt;
    lat = 3; i_req = 1; i_addr = 32'h20;
    nxt; mid;
    `CHK("x_f1_mem_addr", mem_addr, 32'h20);
    nxt; i_flush = 1; mid;
    `CHK("x_f2_i_ready", i_ready, 0);
    nxt; i_flush = 0; mid;
    `CHK("x_f3_mem_ack", mem_ack, 1);
    `CHK("x_f3_i_ready", i_ready, 0);
    `CHK("x_f3_stall_fetch", stall_fetch, 1);
    nxt; i_addr = 32'h24; mid;
    `CHK("x_f4_mem_req", mem_req, 0);
    nxt; mid;
    `CHK("x_f5_mem_addr", mem_addr, 32'h24);
    nxt; nxt; mid;
    `CHK("x_f7_i_ready", i_ready, 1);
    `CHK("x_f7_i_rdata", i_rdata, 32'h5A5A_0024);
    nxt; i_addr = 32'h28; mid;
    `CHK("x_f8_mem_req", mem_req, 0);
    nxt; mid;
    `CHK("x_f9_mem_addr", mem_addr, 32'h28);
    nxt; nxt; i_flush = 1; mid;
    `CHK("x_f11_mem_ack", mem_ack, 1);
    `CHK("x_f11_i_ready", i_ready, 0);
    `CHK("x_f11_stall_fetch", stall_fetch, 1);
    nxt; i_flush = 0; i_addr = 32'h2C; mid;
    `CHK("x_f12_mem_req", mem_req, 0);
    nxt; nxt; nxt; mid;
    `CHK("x_f15_i_ready", i_ready, 1);
    `CHK("x_f15_i_rdata", i_rdata, 32'h5A5A_002C);
    nxt; i_req = 0;
    nxt;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    nxt; mid;
    `CHK("r_d1_mem_req", mem_req, 1);
    #1 reset = 1'b0;
    #1;
    `CHK("r_async_mem_req", mem_req, 0);
    `CHK("r_async_d_ready", d_ready, 0);
    `CHK("r_async_stall_mem", stall_mem, 1);
    nxt; mid;
    `CHK("r_hold_mem_req", mem_req, 0);
    reset = 1'b1;
    nxt; mid;
    `CHK("r_regrant_mem_req", mem_req, 1);
    `CHK("r_regrant_mem_addr", mem_addr, 32'h300);
    nxt; nxt; mid;
    `CHK("r_d_ready", d_ready, 1);
    `CHK("r_d_rdata", d_rdata, 32'h5A5A_0300);
    nxt; d_req = 0; lat = 1;
    nxt;
    d_req = 1; d_addr = 32'h400;
    nxt; mid;
    `CHK("z_1_d_ready", d_ready, 1);
    `CHK("z_1_d_rdata", d_rdata, 32'h5A5A_0400);
    `CHK("z_1_mem_req", mem_req, 1);
    nxt; d_addr = 32'h404; mid;
    `CHK("z_2_d_ready", d_ready, 0);
    `CHK("z_2_mem_req", mem_req, 0);
    nxt; mid;
    `CHK("z_3_d_ready", d_ready, 1);
    `CHK("z_3_d_rdata", d_rdata, 32'h5A5A_0404);
    `CHK("z_3_mem_addr", mem_addr, 32'h404);
    nxt; d_req = 0; mid;
    `CHK("z_4_mem_req", mem_req, 0);
    `CHK("z_4_stall_mem", stall_mem, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
